// File: rtl/serpent_key_sched_seq.sv
// Sequential Serpent-256 key schedule: one prekey word per clock, 33 x 128-bit
// subkeys held stable in DONE until the next accepted start.
module serpent_key_sched_seq (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] key256,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  output logic [127:0] keys [0:32]
);

  localparam logic [31:0] PHI = 32'h9E3779B9;

  typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

  // Serpent S-boxes packed as 16 nibbles, entry n at bits [4n+3:4n].
  function automatic logic [3:0] sbox(input logic [2:0] s, input logic [3:0] x);
    logic [63:0] t;
    case (s)
      3'd0:    t = 64'hC90724DEB56A1F83;
      3'd1:    t = 64'h43D68EB1A50972CF;
      3'd2:    t = 64'h25B04E1DFAC39768;
      3'd3:    t = 64'hE57A421D369C8BF0;
      3'd4:    t = 64'hD7E9A4526B0C38F1;
      3'd5:    t = 64'h176D8E30C9A4B25F;
      3'd6:    t = 64'h0A3DF19EB6485C27;
      default: t = 64'h6539AC47B28E0FD1;
    endcase
    return t[{x, 2'b00} +: 4];
  endfunction

  state_t        state, state_nx;
  logic [7:0]    i;
  logic [31:0]   win [8];
  logic [31:0]   w_mix, w_new;
  logic [2:0]    sel;
  logic [127:0]  sk;
  logic          accept, last;

  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (state == GEN) && (i == 8'd131);
  assign w_mix  = win[0] ^ win[3] ^ win[5] ^ win[7] ^ PHI ^ {24'd0, i};
  assign w_new  = {w_mix[20:0], w_mix[31:21]};
  // Subkey k = i>>2 uses S((3-k) mod 8); only k[2:0] = i[4:2] matters.
  assign sel    = 3'd3 - i[4:2];

  for (genvar b = 0; b < 32; b++) begin : g_slice
    logic [3:0] y;
    assign y = sbox(sel, {w_new[b], win[7][b], win[6][b], win[5][b]});
    assign sk[b]      = y[0];
    assign sk[32+b]   = y[1];
    assign sk[64+b]   = y[2];
    assign sk[96+b]   = y[3];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = GEN;
      GEN:     if (last)   state_nx = DONE;
      DONE:    if (accept) state_nx = GEN;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    keys_valid = 1'b0;
    case (state)
      GEN:     busy       = 1'b1;
      DONE:    keys_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i    <= '0;
      done <= 1'b0;
      for (int j = 0; j < 8; j++)  win[j]  <= '0;
      for (int n = 0; n < 33; n++) keys[n] <= '0;
    end else begin
      done <= last;
      if (accept) begin
        i <= '0;
        for (int j = 0; j < 8; j++) win[j] <= key256[32*j +: 32];
      end else if (state == GEN) begin
        i <= i + 8'd1;
        for (int j = 0; j < 7; j++) win[j] <= win[j+1];
        win[7] <= w_new;
        if (i[1:0] == 2'b11) keys[i[7:2]] <= sk;
      end
    end
  end

endmodule

// File: tb/tb_serpent_key_sched_seq.sv
// Directed + table-driven bench for serpent_key_sched_seq against a word-level
// Serpent-256 key schedule model.
module tb_serpent_key_sched_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [255:0] key256;
  logic         busy, done, keys_valid;
  logic [127:0] keys [0:32];

  serpent_key_sched_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key256(key256),
    .busy(busy), .done(done), .keys_valid(keys_valid), .keys(keys)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  int sb [8][16] = '{
    '{ 3, 8,15, 1,10, 6, 5,11,14,13, 4, 2, 7, 0, 9,12},
    '{15,12, 2, 7, 9, 0, 5,10, 1,11,14, 8, 6,13, 3, 4},
    '{ 8, 6, 7, 9, 3,12,10,15,13, 1,14, 4, 0,11, 5, 2},
    '{ 0,15,11, 8,12, 9, 6, 3,13, 1, 2, 4,10, 7, 5,14},
    '{ 1,15, 8, 3,12, 0,11, 6, 2, 5, 4,10, 9,14, 7,13},
    '{15, 5, 2,11, 4,10, 9,12, 0, 3,14, 8,13, 6, 7, 1},
    '{ 7, 2,12, 5, 8, 4, 6,11,14, 9, 1,15,13, 3,10, 0},
    '{ 1,13,15, 0,14, 8, 2,11, 7, 4,12,10, 9, 3, 5, 6}
  };

  logic [31:0]  mw [140];
  logic [127:0] exp_keys [33];

  typedef struct {
    logic [255:0] key;
    logic [31:0]  w0;
  } vec_t;
  vec_t vecs [4];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference schedule: full prekey array, then per-bit-position nibble lookups.
  task automatic model(input logic [255:0] k);
    for (int j = 0; j < 8; j++) mw[j] = k[32*j +: 32];
    for (int n = 0; n < 132; n++) begin
      logic [31:0] t;
      t = mw[n] ^ mw[n+3] ^ mw[n+5] ^ mw[n+7] ^ 32'h9E3779B9 ^ n;
      mw[n+8] = (t << 11) | (t >> 21);
    end
    for (int kk = 0; kk < 33; kk++) begin
      int s;
      logic [31:0] x0, x1, x2, x3;
      logic [127:0] r;
      s  = (11 - (kk % 8)) % 8;
      x0 = mw[4*kk+8]; x1 = mw[4*kk+9]; x2 = mw[4*kk+10]; x3 = mw[4*kk+11];
      r  = '0;
      for (int b = 0; b < 32; b++) begin
        int nib, y;
        nib = int'(x0[b]) + 2*int'(x1[b]) + 4*int'(x2[b]) + 8*int'(x3[b]);
        y   = sb[s][nib];
        r[b]    = y[0];
        r[32+b] = y[1];
        r[64+b] = y[2];
        r[96+b] = y[3];
      end
      exp_keys[kk] = r;
    end
  endtask

  task automatic launch(input logic [255:0] k);
    start  = 1'b1;
    key256 = k;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  // Runs from just after E0 until done is seen (bounded), returning in the done cycle.
  task automatic run_gen(input bit glitch, input logic [31:0] exp_w0, input string nm);
    int lat;
    bit bad, got;
    lat = 0; bad = 0; got = 0;
    while (lat < 200 && !got) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) chk({nm, "_w0"}, 128'(dut.win[7]), 128'(exp_w0));
      if (glitch && (lat == 10 || lat == 100)) begin
        start  = 1'b1;
        key256 = ~key256;
      end else begin
        start = 1'b0;
      end
      if (done) got = 1;
      else if (keys_valid || !busy) bad = 1;
    end
    chk({nm, "_latency"}, 128'(lat), 128'(132));
    chk({nm, "_gen_flags"}, 128'(bad), 128'(0));
    chk({nm, "_done_state"}, 128'({done, keys_valid, busy}), 128'(3'b110));
  endtask

  task automatic chk_bank(input string nm);
    for (int kk = 0; kk < 33; kk++)
      chk($sformatf("%s_key%0d", nm, kk), keys[kk], exp_keys[kk]);
  endtask

  initial begin
    logic [127:0] acc;
    logic [255:0] ka, kb, kr;

    vecs[0] = '{key: 256'd0, w0: 32'hBBCDCCF1};
    vecs[1] = '{key: {4{64'h0123_4567_89AB_CDEF}}, w0: 32'hFF8988B5};
    vecs[2] = '{key: {256{1'b1}}, w0: 32'hBBCDCCF1};
    vecs[3] = '{key: 256'd1, w0: 32'hBBCDC4F1};

    rst_n = 1'b0; start = 1'b0; key256 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_flags", 128'({busy, done, keys_valid}), 128'(0));
    chk("reset_key0", keys[0], 128'd0);
    chk("reset_key32", keys[32], 128'd0);
    rst_n = 1'b1;

    for (int v = 0; v < 4; v++) begin
      model(vecs[v].key);
      launch(vecs[v].key);
      chk($sformatf("vec%0d_busy_after_accept", v), 128'({busy, keys_valid}), 128'(2'b10));
      run_gen(1'b0, vecs[v].w0, $sformatf("vec%0d", v));
      chk_bank($sformatf("vec%0d", v));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_done_one_cycle", v), 128'({done, keys_valid, busy}), 128'(3'b010));
    end

    // start pulses mid-GEN are ignored, then back-to-back start in the done cycle
    ka = {8{32'hA5A5_0F0F}} ^ 256'h1234;
    kb = {4{64'hDEAD_BEEF_CAFE_F00D}};
    model(ka);
    launch(ka);
    run_gen(1'b1, mw[8], "glitch");
    chk_bank("glitch");
    model(kb);
    launch(kb);
    chk("b2b_valid_drop", 128'({keys_valid, busy, done}), 128'(3'b010));
    run_gen(1'b0, mw[8], "b2b");
    chk_bank("b2b");

    // reset held for two clocks at i = 50
    launch(ka);
    repeat (50) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    acc = '0;
    for (int kk = 0; kk < 33; kk++) acc |= keys[kk];
    chk("midgen_reset_flags", 128'({busy, done, keys_valid}), 128'(0));
    chk("midgen_reset_keys", acc, 128'd0);
    model(ka);
    launch(ka);
    run_gen(1'b0, mw[8], "after_reset");
    chk_bank("after_reset");

    // S-box selection sweep
    for (int r = 0; r < 200; r++) begin
      for (int j = 0; j < 8; j++) kr[32*j +: 32] = $urandom;
      model(kr);
      launch(kr);
      run_gen(1'b0, mw[8], $sformatf("rnd%0d", r));
      chk($sformatf("rnd%0d_k0", r),  keys[0],  exp_keys[0]);
      chk($sformatf("rnd%0d_k3", r),  keys[3],  exp_keys[3]);
      chk($sformatf("rnd%0d_k4", r),  keys[4],  exp_keys[4]);
      chk($sformatf("rnd%0d_k32", r), keys[32], exp_keys[32]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
